// File: rtl/config_pkg.sv
// Shared configuration for the operand collector: default data types, the
// collector FSM state encoding and the upper bound on C operand words.
package config_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int C_WORDS_DEF = 2;
  localparam int C_WORDS_MAX = 4;

  typedef logic [DATA_W_DEF-1:0]             data_t;
  typedef logic [C_WORDS_DEF*DATA_W_DEF-1:0] w_data_t;

  typedef enum logic [1:0] {
    ST_A,
    ST_B,
    ST_C
  } collector_state_t;

endpackage

// File: rtl/operand_out_slot.sv
// One-entry valid/ready holding register. It loads a full payload on load_i
// and drops valid when the consumer takes the entry without a refill.
module operand_out_slot #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         arst_ni,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         take_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q;

  // A load in the same cycle as a take keeps the slot full with new data.
  assign valid_d = load_i | (valid_q & ~take_i);

  always_ff @(posedge clk or negedge arst_ni) begin
    if (!arst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      if (load_i) data_q <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/operand_collector.sv
// Assembles A, B and a multi-word C from a valid/ready word stream and hands
// the finished packet to a registered output slot.
module operand_collector
  import config_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int C_WORDS = 2
) (
  input  logic                        clk,
  input  logic                        arst_ni,
  input  logic                        rd_data_valid_i,
  input  logic [DATA_W-1:0]           rd_data_i,
  output logic                        rd_data_ready_o,
  input  logic                        c_single_i,
  input  logic                        flush_i,
  output logic [DATA_W-1:0]           operand_a_o,
  output logic [DATA_W-1:0]           operand_b_o,
  output logic [C_WORDS*DATA_W-1:0]   operand_c_o,
  output logic                        operation_valid_o,
  input  logic                        operation_ready_i
);

  localparam int  CW      = C_WORDS * DATA_W;
  localparam int  PW      = 2 * DATA_W + CW;
  localparam int  CNT_W   = $clog2(C_WORDS_MAX);
  localparam bit  MULTI_C = (C_WORDS > 1);

  if ((C_WORDS < 1) || (C_WORDS > C_WORDS_MAX)) begin : g_bad_cfg
    $error("operand_collector: C_WORDS must be in 1..4");
  end

  collector_state_t   state_q, state_d;
  logic [CNT_W-1:0]   c_cnt_q, c_cnt_d;
  logic               single_q, single_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic [CW-1:0]      stage_c_q, stage_c_d;

  logic               single_eff;
  logic [CNT_W-1:0]   c_last;
  logic               last_word_pos;
  logic               accept;
  logic               transfer;
  logic               slot_valid;
  logic [CW-1:0]      word_ext;
  logic [CW-1:0]      c_shift;
  logic [CW-1:0]      c_final;
  logic [PW-1:0]      slot_data;

  assign single_eff    = MULTI_C & single_q;
  assign c_last        = single_eff ? '0 : CNT_W'(C_WORDS - 1);
  assign last_word_pos = (state_q == ST_C) && (c_cnt_q == c_last);

  // Only the closing word of a packet waits for the slot; flush blocks all.
  assign rd_data_ready_o = ~flush_i & ~(last_word_pos & slot_valid & ~operation_ready_i);
  assign accept          = rd_data_valid_i & rd_data_ready_o;
  assign transfer        = accept & last_word_pos;

  assign word_ext = CW'(rd_data_i);
  assign c_shift  = (stage_c_q << DATA_W) | word_ext;
  assign c_final  = single_eff ? word_ext : c_shift;

  always_comb begin
    state_d   = state_q;
    c_cnt_d   = c_cnt_q;
    single_d  = single_q;
    a_d       = a_q;
    b_d       = b_q;
    stage_c_d = stage_c_q;
    if (flush_i) begin
      state_d   = ST_A;
      c_cnt_d   = '0;
      single_d  = 1'b0;
      a_d       = '0;
      b_d       = '0;
      stage_c_d = '0;
    end else if (accept) begin
      unique case (state_q)
        ST_A: begin
          a_d      = rd_data_i;
          single_d = c_single_i;
          state_d  = ST_B;
        end
        ST_B: begin
          b_d     = rd_data_i;
          c_cnt_d = '0;
          state_d = ST_C;
        end
        ST_C: begin
          if (last_word_pos) begin
            c_cnt_d   = '0;
            stage_c_d = '0;
            state_d   = ST_A;
          end else begin
            stage_c_d = c_shift;
            c_cnt_d   = c_cnt_q + 1'b1;
          end
        end
        default: state_d = ST_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q   <= ST_A;
      c_cnt_q   <= '0;
      single_q  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      stage_c_q <= '0;
    end else begin
      state_q   <= state_d;
      c_cnt_q   <= c_cnt_d;
      single_q  <= single_d;
      a_q       <= a_d;
      b_q       <= b_d;
      stage_c_q <= stage_c_d;
    end
  end

  operand_out_slot #(
    .W (PW)
  ) u_slot (
    .clk     (clk),
    .arst_ni (arst_ni),
    .load_i  (transfer),
    .data_i  ({a_q, b_q, c_final}),
    .take_i  (operation_ready_i),
    .valid_o (slot_valid),
    .data_o  (slot_data)
  );

  assign operation_valid_o = slot_valid;
  assign operand_a_o       = slot_data[PW-1 -: DATA_W];
  assign operand_b_o       = slot_data[CW+DATA_W-1 -: DATA_W];
  assign operand_c_o       = slot_data[CW-1:0];

endmodule
